// File: rtl/tv_timing_pkg.sv
// Shared composite-video timing definitions.
// Pulse classes and default PAL timing, used by decoder and encoder.
package tv_timing_pkg;

  typedef enum logic [2:0] {
    PC_NONE,
    PC_GLITCH,
    PC_EQ,
    PC_HS,
    PC_BROAD
  } pulse_cls_t;

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } lock_state_t;

  localparam int SYNC_THRESH_DEF = 2;
  localparam int LINE_CLKS_DEF   = 1536;
  localparam int LOCK_TOL_DEF    = 8;
  localparam int GLITCH_MAX_DEF  = 16;
  localparam int EQ_MAX_DEF      = 85;
  localparam int HS_MAX_DEF      = 300;

  function automatic pulse_cls_t classify(
    input logic [9:0] w,
    input int         gmax,
    input int         eqmax,
    input int         hsmax
  );
    int wi;
    wi = int'(w);
    if (w == 10'h3FF)    return PC_BROAD;
    else if (wi < gmax)  return PC_GLITCH;
    else if (wi < eqmax) return PC_EQ;
    else if (wi < hsmax) return PC_HS;
    else                 return PC_BROAD;
  endfunction

endpackage

// File: rtl/pal_sync_decoder_slicer.sv
// Sync slicer: input register, threshold compare, width count, classify.
// Emits a one-cycle class strobe on each sync_n rising edge.
module sync_slicer
  import tv_timing_pkg::*;
#(
  parameter int SYNC_THRESH = SYNC_THRESH_DEF,
  parameter int GLITCH_MAX  = GLITCH_MAX_DEF,
  parameter int EQ_MAX      = EQ_MAX_DEF,
  parameter int HS_MAX      = HS_MAX_DEF
) (
  input  logic       clk24,
  input  logic       reset_n,
  input  logic [7:0] cvbs,
  output logic       sync_n,
  output logic       cls_vld,
  output pulse_cls_t cls
);

  localparam logic [7:0] THR = 8'(SYNC_THRESH);

  logic       sync_d;
  logic [9:0] width;

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      sync_n <= 1'b1;
      sync_d <= 1'b1;
      width  <= '0;
    end else begin
      sync_n <= (cvbs >= THR);
      sync_d <= sync_n;
      if (sync_n)
        width <= '0;
      else if (width != 10'h3FF)
        width <= width + 10'd1;
    end
  end

  assign cls_vld = sync_n & ~sync_d;
  assign cls = cls_vld
             ? classify(width, GLITCH_MAX, EQ_MAX, HS_MAX)
             : PC_NONE;

endmodule

// File: rtl/pal_sync_decoder.sv
// PAL sync decoder: line lock with flywheel, field detect,
// line/x counters and burst gate.
module pal_sync_decoder
  import tv_timing_pkg::*;
#(
  parameter int SYNC_THRESH = SYNC_THRESH_DEF,
  parameter int LINE_CLKS   = LINE_CLKS_DEF,
  parameter int LOCK_TOL    = LOCK_TOL_DEF,
  parameter int GLITCH_MAX  = GLITCH_MAX_DEF,
  parameter int EQ_MAX      = EQ_MAX_DEF,
  parameter int HS_MAX      = HS_MAX_DEF
) (
  input  logic        clk24,
  input  logic        reset_n,
  input  logic [7:0]  cvbs,
  output logic        sync_n,
  output logic        hs_pulse,
  output logic        hs_synth,
  output logic        vs_pulse,
  output logic        field,
  output logic [9:0]  line,
  output logic [10:0] xpos,
  output logic        burst_gate,
  output logic        locked,
  output logic        pulse_err
);

  // xpos doubles as the period counter; at a strobe it reads spacing-1
  localparam logic [10:0] WIN_LO = 11'(LINE_CLKS - LOCK_TOL - 1);
  localparam logic [10:0] WIN_HI = 11'(LINE_CLKS + LOCK_TOL - 1);

  logic        cls_vld;
  pulse_cls_t  cls;

  lock_state_t state, state_nx;
  logic [2:0]  good_cnt, good_nx;
  logic [1:0]  miss_cnt, miss_nx;
  logic [1:0]  broad_cnt, broad_nx;
  logic        hs_nx, synth_nx, vs_nx, err_nx;
  logic        is_hs, is_eq, is_broad, in_win, fly;

  sync_slicer #(
    .SYNC_THRESH (SYNC_THRESH),
    .GLITCH_MAX  (GLITCH_MAX),
    .EQ_MAX      (EQ_MAX),
    .HS_MAX      (HS_MAX)
  ) u_slicer (
    .clk24   (clk24),
    .reset_n (reset_n),
    .cvbs    (cvbs),
    .sync_n  (sync_n),
    .cls_vld (cls_vld),
    .cls     (cls)
  );

  assign is_hs    = cls_vld && (cls == PC_HS);
  assign is_eq    = cls_vld && (cls == PC_EQ);
  assign is_broad = cls_vld && (cls == PC_BROAD);
  assign in_win   = (xpos >= WIN_LO) && (xpos <= WIN_HI);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    miss_nx  = miss_cnt;
    broad_nx = broad_cnt;
    hs_nx    = 1'b0;
    synth_nx = 1'b0;
    vs_nx    = 1'b0;
    err_nx   = cls_vld && (cls == PC_GLITCH);
    fly      = 1'b0;

    if (is_hs)
      broad_nx = '0;
    else if (is_broad && broad_cnt != 2'd3) begin
      broad_nx = broad_cnt + 2'd1;
      vs_nx    = (broad_cnt == 2'd2);
    end

    unique case (state)
      ST_HUNT: begin
        if (is_hs) begin
          hs_nx   = 1'b1;
          good_nx = in_win ? good_cnt + 3'd1 : 3'd1;
          if (good_nx == 3'd4) begin
            state_nx = ST_LOCKED;
            miss_nx  = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (is_hs && in_win) begin
          hs_nx   = 1'b1;
          miss_nx = '0;
        end else if (is_hs)
          err_nx = 1'b1;
        else if (is_eq || is_broad)
          miss_nx = '0;
        fly = !hs_nx && (xpos == WIN_HI);
        if (fly) begin
          hs_nx    = 1'b1;
          synth_nx = 1'b1;
          miss_nx  = miss_cnt + 2'd1;
          if (miss_cnt == 2'd1) begin
            state_nx = ST_HUNT;
            good_nx  = '0;
          end
        end
      end
      default: state_nx = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_HUNT;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      broad_cnt <= '0;
      hs_pulse  <= 1'b0;
      hs_synth  <= 1'b0;
      vs_pulse  <= 1'b0;
      pulse_err <= 1'b0;
      field     <= 1'b0;
      locked    <= 1'b0;
      line      <= '0;
      xpos      <= '0;
    end else begin
      state     <= state_nx;
      good_cnt  <= good_nx;
      miss_cnt  <= miss_nx;
      broad_cnt <= broad_nx;
      hs_pulse  <= hs_nx;
      hs_synth  <= synth_nx;
      vs_pulse  <= vs_nx;
      pulse_err <= err_nx;
      locked    <= (state == ST_LOCKED);
      if (vs_nx)
        field <= ~field;
      if (hs_nx)
        xpos <= '0;
      else if (xpos != 11'h7FF)
        xpos <= xpos + 11'd1;
      if (vs_nx)
        line <= '0;
      else if (hs_nx && line != 10'h3FF)
        line <= line + 10'd1;
    end
  end

  assign burst_gate = locked && (xpos >= 11'd24) && (xpos <= 11'd98);

endmodule

// File: doc/pal_sync_decoder.md
# pal_sync_decoder

Composite-video sync decoder for the TV-out path. It slices 8-bit CVBS samples, here the composite luma bus, at the sync threshold and classifies each sync pulse as equalizing, normal or broad by its width. From those pulses it recovers line and field timing, keeping lines going with a flywheel when pulses are missing. Its outputs (line/field strobes, line number, x position, colourburst gate, lock flag) serve the loopback self-test and a future capture path.

## Interface
Parameters:
- SYNC_THRESH, 2: sample < SYNC_THRESH counts as sync level
- LINE_CLKS, 1536: nominal line period in clk24 cycles (64 µs)
- LOCK_TOL, 8: accepted line-period deviation, ±cycles
- GLITCH_MAX, 16: low pulses shorter than this are glitches
- EQ_MAX, 85: width < EQ_MAX → equalizing pulse
- HS_MAX, 300: width < HS_MAX → normal hsync; otherwise broad

Ports:
- clk24  in  1  system clock, 24 MHz
- reset_n  in  1  asynchronous, active-low reset
- cvbs  in  8  composite sample, one per clk24
- sync_n  out  1  registered slicer output (0 = sync level)
- hs_pulse  out  1  one-cycle line-start strobe (real or flywheel)
- hs_synth  out  1  qualifies hs_pulse as flywheel-generated
- vs_pulse  out  1  one-cycle field-start strobe
- field  out  1  toggles on each vs_pulse
- line  out  10  line number since vs_pulse, saturates at 1023
- xpos  out  11  cycles since last hs_pulse, saturates at 2047
- burst_gate  out  1  locked & xpos in [24,98]
- locked  out  1  line lock achieved
- pulse_err  out  1  one-cycle strobe: glitch or out-of-window hsync

## Operation
- Slicer: sync_n <= (cvbs >= SYNC_THRESH). Width counter (10 b, saturating at 1023) runs while sync_n = 0.
- Classification happens on the rising edge of sync_n:
  - width < GLITCH_MAX → glitch: pulse_err, pulse otherwise ignored.
  - width < EQ_MAX → EQ.
  - width < HS_MAX → HS.
  - otherwise → BROAD.
- Period counter (11 b) clears on every hs_pulse and otherwise increments.
- State HUNT (reset state):
  - Every HS pulse is accepted and produces hs_pulse.
  - good_cnt increments if the period is within LINE_CLKS±LOCK_TOL, else good_cnt = 1.
  - good_cnt reaching 4 → LOCKED, miss_cnt = 0.
- State LOCKED:
  - HS pulse with period inside the window → hs_pulse, miss_cnt = 0.
  - HS pulse outside the window → pulse_err, no hs_pulse.
  - EQ or BROAD pulse → miss_cnt = 0.
  - Period reaching LINE_CLKS+LOCK_TOL → flywheel: hs_pulse with hs_synth, miss_cnt++.
  - miss_cnt reaching 2 → HUNT, good_cnt = 0.
- Vertical detection:
  - broad_cnt (2 b, saturating at 3) counts consecutive BROAD pulses; an HS pulse clears it, EQ pulses leave it unchanged.
  - The transition of broad_cnt from 2 to 3 produces vs_pulse, line <= 0 and toggles field. This happens once per broad sequence, in either state.
- line increments on each hs_pulse (saturating). vs_pulse takes precedence when both occur in the same cycle.
- xpos clears on hs_pulse and otherwise increments (saturating).

## Timing
- Reset values: sync_n = 1; hs_pulse, hs_synth, vs_pulse, pulse_err, field, locked, burst_gate = 0; line = 0; xpos = 0; state = HUNT; all counters 0.
- cvbs is registered once, so sync_n lags cvbs by 1 cycle.
- Classification strobes, and therefore hs_pulse, vs_pulse and pulse_err, are asserted 2 cycles after the first sample at or above the threshold.
- A flywheel hs_pulse fires in the cycle the period counter equals LINE_CLKS+LOCK_TOL−1.
- A real pulse that classifies in the same cycle as a flywheel strobe counts as real: hs_synth = 0, no miss counted.
- locked rises in the cycle after the 4th good hs_pulse and falls in the cycle after the 2nd consecutive flywheel.
- A width counter still saturated at 1023 at the rising edge is classified BROAD.
- reset_n low mid-pulse clears everything immediately. The pulse in progress at release counts from release.

## Structure
- Shared tv_timing package: the pulse class encoding (NONE/GLITCH/EQ/HS/BROAD) and the default timing constants, also usable by the encoder side.
- One sub-module, sync_slicer: input register, comparator, width counter and classifier. It outputs a class strobe plus the class code.
- The lock/flywheel FSM and the line/field counters live in the top module.

## Test plan
- 8 normal lines (114-cycle pulse at level 0, period 1536, level 4 elsewhere) → locked high after the 4th hs_pulse; xpos at a line end = 1535 → 0.
- 5 broad pulses (655 cycles at 768 spacing) after 10 locked lines → exactly one vs_pulse (on the 3rd broad), line = 0, field toggles.
- Locked, then one 114-cycle pulse removed → hs_synth strobe at period 1543, locked stays high; two removed → locked falls.
- 10-cycle low glitch mid-line → pulse_err, no hs_pulse, line unchanged.
- Locked, HS pulse at period 1400 → pulse_err, no hs_pulse; flywheel fires at 1543.
- reset_n asserted low mid-broad-pulse → all outputs at reset values the next cycle; relock after 4 good lines.
